// File: rtl/core_pkg.sv
// Shared types and constants for the load/store unit: funct3 memory opcodes,
// LSU FSM states, datapath widths and the illegal-access decode.
package core_pkg;

    localparam int XLEN    = 32;
    localparam int MEMOP_W = 3;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } memop_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Loads have no 011/110/111 forms; stores only exist as 000..010.
    function automatic logic is_illegal(input logic rd, input logic wr,
                                        input logic [MEMOP_W-1:0] op);
        logic ill;
        if (rd && wr) begin
            ill = 1'b1;
        end else if (rd) begin
            ill = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
        end else begin
            ill = (op > 3'b010);
        end
        return ill;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extract with
// sign/zero extension, and size-based misalign detection.
module lsu_align
    import core_pkg::*;
(
    input  logic [MEMOP_W-1:0] op,
    input  logic [1:0]         addr_lo,
    input  logic [XLEN-1:0]    wdata,
    input  logic [XLEN-1:0]    rdata,
    output logic [XLEN-1:0]    st_data,
    output logic [XLEN/8-1:0]  st_strb,
    output logic [XLEN-1:0]    ld_data,
    output logic               misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lanes, strobes and alignment by access size.
    always_comb begin
        st_data  = wdata;
        st_strb  = 4'b1111;
        misalign = 1'b0;
        case (op[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_strb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                st_data  = {2{wdata[15:0]}};
                st_strb  = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            2'b10: begin
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                misalign = 1'b0;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        case (addr_lo)
            2'b00:   ld_byte = rdata[7:0];
            2'b01:   ld_byte = rdata[15:8];
            2'b10:   ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        if (addr_lo[1]) begin
            ld_half = rdata[31:16];
        end else begin
            ld_half = rdata[15:0];
        end
        case (op)
            MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_BU:  ld_data = {24'd0, ld_byte};
            MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_HU:  ld_data = {16'd0, ld_half};
            MEM_W:   ld_data = rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle load/store unit FSM (IDLE/REQ/WAIT/DONE) with registered outputs.
module lsu_mem
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [MEMOP_W-1:0] req_opcode,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               rsp_valid,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               rsp_misalign,
    output logic               rsp_illegal,
    output logic               lsu_busy,
    output logic               bus_req_valid,
    input  logic               bus_req_ready,
    output logic               bus_req_write,
    output logic [XLEN-1:0]    bus_req_addr,
    output logic [XLEN-1:0]    bus_req_wdata,
    output logic [XLEN/8-1:0]  bus_req_wstrb,
    input  logic               bus_rsp_valid,
    input  logic [XLEN-1:0]    bus_rsp_rdata
);

    lsu_state_e         state;
    logic [MEMOP_W-1:0] op;
    logic [1:0]         addr_lo;
    logic               accept;
    logic               illegal;
    logic [MEMOP_W-1:0] a_op;
    logic [1:0]         a_addr_lo;
    logic [XLEN-1:0]    st_data;
    logic [XLEN/8-1:0]  st_strb;
    logic [XLEN-1:0]    ld_data;
    logic               misalign;

    // The align block sees the live request in IDLE and the latched op afterwards.
    always_comb begin
        accept  = (state == IDLE) && req_ready && req_valid && (req_read || req_write);
        illegal = is_illegal(req_read, req_write, req_opcode);
        if (state == IDLE) begin
            a_op      = req_opcode;
            a_addr_lo = req_addr[1:0];
        end else begin
            a_op      = op;
            a_addr_lo = addr_lo;
        end
    end

    lsu_align u_align (
        .op       (a_op),
        .addr_lo  (a_addr_lo),
        .wdata    (req_wdata),
        .rdata    (bus_rsp_rdata),
        .st_data  (st_data),
        .st_strb  (st_strb),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    // Main FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op            <= 3'b000;
            addr_lo       <= 2'b00;
            req_ready     <= 1'b0;
            lsu_busy      <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'd0;
            rsp_misalign  <= 1'b0;
            rsp_illegal   <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_write <= 1'b0;
            bus_req_addr  <= 32'd0;
            bus_req_wdata <= 32'd0;
            bus_req_wstrb <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op            <= req_opcode;
                        addr_lo       <= req_addr[1:0];
                        req_ready     <= 1'b0;
                        lsu_busy      <= 1'b1;
                        bus_req_write <= req_write;
                        bus_req_addr  <= {req_addr[31:2], 2'b00};
                        bus_req_wdata <= req_write ? st_data : 32'd0;
                        bus_req_wstrb <= req_write ? st_strb : 4'b1111;
                        if (illegal || misalign) begin
                            state        <= DONE;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= 32'd0;
                            rsp_illegal  <= illegal;
                            rsp_misalign <= !illegal && misalign;
                        end else begin
                            state         <= REQ;
                            bus_req_valid <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        if (bus_req_write) begin
                            state        <= DONE;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= 32'd0;
                            rsp_illegal  <= 1'b0;
                            rsp_misalign <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        state        <= DONE;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= ld_data;
                        rsp_illegal  <= 1'b0;
                        rsp_misalign <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    lsu_busy  <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
